// File: rtl/ntt_pipe_drain.sv
// ntt_pipe_drain: receive FIFO behind a fixed-latency, non-stallable pipe, with credit-gated issue.
// Build option NTT_DRAIN_BYPASS_EN: an empty FIFO forwards pipe_data to the output in the same cycle.
module ntt_pipe_drain #(
    parameter int DATA_W  = 14,
    parameter int LATENCY = 7,
    parameter int DEPTH   = 16,
    parameter int AW      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    output logic              issue_ok,
    input  logic              pipe_vld,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              err
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       inflight;
    logic [AW+1:0]     credit;
    logic              empty, room, pop, push, drop, take, retire;

    assign empty  = (count == '0);
    assign room   = (count < FULL);
    // pop only ever drains stored entries; a bypassed item never touches the pointers
    assign pop    = !empty && out_ready;
    assign retire = pipe_vld && (inflight != '0);

`ifdef NTT_DRAIN_BYPASS_EN
    assign take      = empty && pipe_vld && out_ready;
    assign out_valid = !empty || pipe_vld;
    assign out_data  = !empty ? mem[rd_ptr] : (pipe_vld ? pipe_data : '0);
`else
    assign take      = 1'b0;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
`endif

    assign push = pipe_vld && !take && (room || pop);
    assign drop = pipe_vld && !(room || pop);

    // every launched item already owns a slot, so exits can never overflow
    assign credit   = {1'b0, count} + {1'b0, inflight};
    assign issue_ok = (credit < {1'b0, FULL});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({issue, retire})
                2'b10:   if (inflight != '1) inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            if ((issue && !issue_ok) || drop || (pipe_vld && inflight == '0))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pipe_data;
    end

    depth_covers_latency: assert property (@(posedge clk) disable iff (rst) DEPTH >= LATENCY + 1);

endmodule

// File: tb/tb_ntt_pipe_drain.sv
// Bench for ntt_pipe_drain: directed scenarios plus random traffic against a queue-based model.
module tb_ntt_pipe_drain;

    localparam int DATA_W  = 14;
    localparam int LATENCY = 7;
    localparam int DEPTH   = 16;
    localparam int AW      = 4;
`ifdef NTT_DRAIN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, issue, issue_ok, pipe_vld, out_valid, out_ready, err;
    logic [DATA_W-1:0] pipe_data, out_data;
    logic [AW:0]       count;

    ntt_pipe_drain #(.DATA_W(DATA_W), .LATENCY(LATENCY), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .issue(issue), .issue_ok(issue_ok),
        .pipe_vld(pipe_vld), .pipe_data(pipe_data), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: stored items, launched-but-not-exited count, sticky error
    logic [DATA_W-1:0] q[$];
    int                infl;
    bit                m_err;
    // upstream delay line emulating the fixed-latency pipe
    bit                dl_v [LATENCY];
    logic [DATA_W-1:0] dl_d [LATENCY];

    task automatic step(input bit iss, input bit rdy, input bit fv = 1'b0,
                        input logic [DATA_W-1:0] fd = '0);
        bit m_ok, m_vld, pf, take, room, dec;
        logic [DATA_W-1:0] m_dat;
        issue     = iss;
        out_ready = rdy;
        pipe_vld  = dl_v[LATENCY-1] | fv;
        pipe_data = fv ? fd : dl_d[LATENCY-1];
        m_ok  = (q.size() + infl) < DEPTH;
        m_vld = (q.size() != 0) || (BYP && pipe_vld);
        m_dat = (q.size() != 0) ? q[0] : ((BYP && pipe_vld) ? pipe_data : '0);
        @(negedge clk);
        chk("issue_ok", issue_ok, m_ok);
        chk("out_valid", out_valid, m_vld);
        chk("out_data", out_data, m_dat);
        chk("count", count, q.size());
        chk("err", err, m_err);
        pf   = (q.size() != 0) && rdy;
        take = BYP && (q.size() == 0) && pipe_vld && rdy;
        room = q.size() < DEPTH;
        if (iss && !m_ok) m_err = 1'b1;
        if (pipe_vld && !(room || pf)) m_err = 1'b1;
        if (pipe_vld && infl == 0) m_err = 1'b1;
        if (pf) void'(q.pop_front());
        if (pipe_vld && !take && (room || pf)) q.push_back(pipe_data);
        dec  = pipe_vld && infl > 0;
        infl = infl + int'(iss) - int'(dec);
        for (int i = LATENCY-1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = iss;
        dl_d[0] = DATA_W'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue = 1'b0; pipe_vld = 1'b0; out_ready = 1'b0; pipe_data = '0;
        q.delete();
        infl = 0;
        m_err = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();

        // build count=5 with 3 still in flight, then reset mid-burst
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("t1_count5", count, 5);
        do_reset();

        // streaming at full rate
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("t2_err", err, 0);

        // backpressure: issue only while the DUT grants credit
        do_reset();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            n += int'(issue_ok);
            step(issue_ok, 1'b0);
        end
        chk("t3_issued", n, 16);
        chk("t3_count", count, 16);
        chk("t3_err", err, 0);

        // full FIFO with simultaneous forced exit and pop
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, DATA_W'($urandom));
        chk("t4_count", count, 16);

        // issue without credit
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
        chk("t5_err_issue", err, 1);
        // exit with nothing in flight
        do_reset();
        step(1'b0, 1'b0, 1'b1, 14'h0AB);
        chk("t5_err_vld", err, 1);
        chk("t5_count", count, 1);

        // bypass / latency on an empty FIFO
        do_reset();
        step(1'b0, 1'b1, 1'b1, 14'h1A5);
        chk("t6_count", count, BYP ? 0 : 1);
        step(1'b0, 1'b0);

        // random traffic, occasionally violating credit
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit rogue, iss, rdy;
            rogue = ($urandom_range(0, 49) == 0);
            iss   = (issue_ok && $urandom_range(0, 3) != 0) || rogue;
            rdy   = (i % 200 < 100) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            step(iss, rdy);
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
